// File: rtl/rv_hazard_ctrl_pkg.sv
// rv_hazard_ctrl_pkg: shared state and forwarding-select encodings for the hazard controller
package rv_hazard_ctrl_pkg;
    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        REDIRECT = 3'd2,
        TRAP     = 3'd3
    } hazard_state_t;
    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_ALU2 = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_t;
endpackage

// File: rtl/rv_hazard_ctrl_fwd_sel.sv
// rv_hazard_ctrl_fwd_sel: picks the operand source for one decode rs index against the ALU1/ALU2 destinations
module rv_hazard_ctrl_fwd_sel
    import rv_hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] alu1_rd,
    input  logic       alu1_we,
    input  logic [4:0] alu2_rd,
    input  logic       alu2_we,
    output logic [1:0] sel
);
    // ALU1 holds the younger producer, so its match takes precedence
    always_comb
        sel = (rs != 5'd0 && alu1_we && alu1_rd == rs) ? FWD_ALU2 :
              (rs != 5'd0 && alu2_we && alu2_rd == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl: load-use bubbles, registered forwarding selects, memory-wait, redirect and trap sequencing.
// Define RV_HAZARD_PERF_EN to add saturating fetch-stall and redirect/trap event counters.
module rv_hazard_ctrl
    import rv_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES     = 2,
    parameter int IADDR_SPACE_BITS = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_dec_valid,
    input  logic [4:0] i_dec_rs1,
    input  logic [4:0] i_dec_rs2,
    input  logic [4:0] i_alu1_rd,
    input  logic       i_alu1_reg_write,
    input  logic       i_alu1_load,
    input  logic [4:0] i_alu2_rd,
    input  logic       i_alu2_reg_write,
    input  logic       i_pc_change,
    input  logic       i_trap,
    input  logic       i_mem_busy,
    output logic       o_fetch_stall,
    output logic       o_dec_stall,
    output logic       o_dec_flush,
    output logic       o_alu1_stall,
    output logic       o_alu1_flush,
    output logic       o_alu2_stall,
    output logic       o_alu2_flush,
    output logic [1:0] o_fwd1_sel,
    output logic [1:0] o_fwd2_sel,
    output logic [2:0] o_state
`ifdef RV_HAZARD_PERF_EN
    ,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
`endif
);
    localparam logic [2:0] CNT_LOAD   = 3'(FLUSH_CYCLES - 1);
    localparam bit         LONG_FLUSH = FLUSH_CYCLES > 1;

    hazard_state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       pending, pending_nx;
    logic [1:0] fwd1, fwd2, fwd1_nx, fwd2_nx;
    logic       load_use, redirect_evt, a1_hold;
    logic       f_stall, d_stall, d_flush, a1_stall, a1_flush, a2_stall, a2_flush;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || IADDR_SPACE_BITS < 1) begin : g_bad_cfg
        $error("rv_hazard_ctrl: parameter out of range");
    end

    rv_hazard_ctrl_fwd_sel u_fwd1 (
        .rs(i_dec_rs1), .alu1_rd(i_alu1_rd), .alu1_we(i_alu1_reg_write),
        .alu2_rd(i_alu2_rd), .alu2_we(i_alu2_reg_write), .sel(fwd1_nx)
    );
    rv_hazard_ctrl_fwd_sel u_fwd2 (
        .rs(i_dec_rs2), .alu1_rd(i_alu1_rd), .alu1_we(i_alu1_reg_write),
        .alu2_rd(i_alu2_rd), .alu2_we(i_alu2_reg_write), .sel(fwd2_nx)
    );

    assign load_use = i_dec_valid && i_alu1_load && i_alu1_reg_write && i_alu1_rd != 5'd0 &&
                      (i_alu1_rd == i_dec_rs1 || i_alu1_rd == i_dec_rs2);
    // a redirect seen during a memory wait is deferred until the wait ends
    assign redirect_evt = (state == RUN || state == REDIRECT) ? i_pc_change :
                          (state == MEM_WAIT) ? (!i_mem_busy && (pending || i_pc_change)) : 1'b0;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        {f_stall, d_stall, d_flush, a1_stall, a1_flush, a2_stall, a2_flush} = '0;
        if (i_trap) begin
            {d_flush, a1_flush, a2_flush} = '1;
            pending_nx = 1'b0;
            state_nx   = TRAP;
        end else if (state == TRAP) begin
            {f_stall, d_flush} = '1;
            cnt_nx   = CNT_LOAD;
            state_nx = LONG_FLUSH ? REDIRECT : RUN;
        end else if (redirect_evt) begin
            {d_flush, a1_flush, a2_flush} = '1;
            cnt_nx     = CNT_LOAD;
            pending_nx = 1'b0;
            state_nx   = LONG_FLUSH ? REDIRECT : RUN;
        end else if (state == REDIRECT) begin
            d_flush  = 1'b1;
            cnt_nx   = cnt - 3'd1;
            state_nx = cnt <= 3'd1 ? RUN : REDIRECT;
        end else if (i_mem_busy) begin
            {f_stall, d_stall, a1_stall, a2_stall} = '1;
            pending_nx = pending | i_pc_change;
            state_nx   = MEM_WAIT;
        end else if (state == MEM_WAIT) begin
            state_nx = RUN;
        end else if (load_use) begin
            {f_stall, d_stall, a1_flush} = '1;
        end
    end

    assign a1_hold = a1_stall & ~a1_flush;

    // outputs are forced low while reset is held, whatever the inputs do
    assign o_fetch_stall = i_reset_n & f_stall;
    assign o_dec_stall   = i_reset_n & d_stall & ~d_flush;
    assign o_dec_flush   = i_reset_n & d_flush;
    assign o_alu1_stall  = i_reset_n & a1_hold;
    assign o_alu1_flush  = i_reset_n & a1_flush;
    assign o_alu2_stall  = i_reset_n & a2_stall & ~a2_flush;
    assign o_alu2_flush  = i_reset_n & a2_flush;
    assign o_fwd1_sel    = fwd1;
    assign o_fwd2_sel    = fwd2;
    assign o_state       = state;

    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state   <= RUN;
            cnt     <= 3'd0;
            pending <= 1'b0;
            fwd1    <= 2'b00;
            fwd2    <= 2'b00;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pending_nx;
            if (!a1_hold) begin
                fwd1 <= a1_flush ? 2'b00 : fwd1_nx;
                fwd2 <= a1_flush ? 2'b00 : fwd2_nx;
            end
        end

`ifdef RV_HAZARD_PERF_EN
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            o_stall_cnt <= 32'd0;
            o_flush_cnt <= 32'd0;
        end else begin
            if (f_stall && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 32'd1;
            if ((i_trap || redirect_evt) && o_flush_cnt != '1)
                o_flush_cnt <= o_flush_cnt + 32'd1;
        end
`endif
endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb_rv_hazard_ctrl: directed vectors for rv_hazard_ctrl (FLUSH_CYCLES=3) checked through a scoreboard queue
module tb_rv_hazard_ctrl;
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] STL  = 7'b1101010;
    localparam logic [6:0] FL3  = 7'b0010101;
    localparam logic [6:0] DFL  = 7'b0010000;
    localparam logic [6:0] TRP  = 7'b1010000;
    localparam logic [2:0] S_RUN = 3'd0, S_MW = 3'd1, S_RD = 3'd2, S_TR = 3'd3;

    typedef struct {
        string      nm;
        logic [13:0] bits;
    } exp_t;

    logic clk, rst_n;
    logic dec_valid, alu1_we, alu1_ld, alu2_we, pc_change, trap, mem_busy;
    logic [4:0] rs1, rs2, alu1_rd, alu2_rd;
    logic fetch_stall, dec_stall, dec_flush, alu1_stall, alu1_flush, alu2_stall, alu2_flush;
    logic [1:0] fwd1, fwd2;
    logic [2:0] st;
`ifdef RV_HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;

    rv_hazard_ctrl #(.FLUSH_CYCLES(3)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_dec_valid(dec_valid),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2),
        .i_alu1_rd(alu1_rd), .i_alu1_reg_write(alu1_we), .i_alu1_load(alu1_ld),
        .i_alu2_rd(alu2_rd), .i_alu2_reg_write(alu2_we),
        .i_pc_change(pc_change), .i_trap(trap), .i_mem_busy(mem_busy),
        .o_fetch_stall(fetch_stall), .o_dec_stall(dec_stall), .o_dec_flush(dec_flush),
        .o_alu1_stall(alu1_stall), .o_alu1_flush(alu1_flush),
        .o_alu2_stall(alu2_stall), .o_alu2_flush(alu2_flush),
        .o_fwd1_sel(fwd1), .o_fwd2_sel(fwd2), .o_state(st)
`ifdef RV_HAZARD_PERF_EN
        , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] act_bits();
        return {fetch_stall, dec_stall, dec_flush, alu1_stall, alu1_flush, alu2_stall, alu2_flush, fwd1, fwd2, st};
    endfunction

    task automatic check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (fs ds df a1s a1f a2s a2f f1 f2 st)", nm, act, exp);
        end
    endtask

    task automatic step(input string nm, input logic v, input logic [4:0] r1, r2, a1, input logic a1w, a1l,
                        input logic [4:0] a2, input logic a2w, pc, tr, bz,
                        input logic [6:0] sf, input logic [1:0] f1, f2, input logic [2:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        dec_valid = v; rs1 = r1; rs2 = r2; alu1_rd = a1; alu1_we = a1w; alu1_ld = a1l;
        alu2_rd = a2; alu2_we = a2w; pc_change = pc; trap = tr; mem_busy = bz;
        e.nm = nm;
        e.bits = {sf, f1, f2, s};
        sb.push_back(e);
    endtask

    always @(negedge clk)
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check(e.nm, act_bits(), e.bits);
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        dec_valid = 0; rs1 = 0; rs2 = 0; alu1_rd = 0; alu1_we = 0; alu1_ld = 0;
        alu2_rd = 0; alu2_we = 0; pc_change = 1; trap = 1; mem_busy = 1;
        #2;
        check("reset", act_bits(), 14'd0);
        pc_change = 0; trap = 0; mem_busy = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        //    name        v r1 r2 a1 w l  a2 w  pc tr bz  exp  f1     f2     st
        step("idle",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("lu",        1, 1, 5, 5, 1, 1, 0, 0, 0, 0, 0, LU,   2'b00, 2'b00, S_RUN);
        step("lu_next",   1, 1, 5, 0, 0, 0, 5, 1, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("lu_fwd",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b10, S_RUN);
        step("prio",      1, 3, 0, 3, 1, 0, 3, 1, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("prio_x0",   1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, NONE, 2'b01, 2'b00, S_RUN);
        step("we_gate",   1, 0, 7, 7, 0, 0, 7, 1, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("fwd_shown", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b10, S_RUN);
        step("mw1",       1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_RUN);
        step("mw2",       1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("mw3",       1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("mw4",       1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("mw_rel",    1, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_MW);
        step("mw_done",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b01, 2'b00, S_RUN);
        step("mp1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_RUN);
        step("mp2_pc",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("mp3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("mp_rel",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL3,  2'b00, 2'b00, S_MW);
        step("mp_rd1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("mp_rd2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("mp_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("rd0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FL3,  2'b00, 2'b00, S_RUN);
        step("rd1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("rd2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("rd_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("bb0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FL3,  2'b00, 2'b00, S_RUN);
        step("bb1",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FL3,  2'b00, 2'b00, S_RD);
        step("bb2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("bb3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("bb_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("tm1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_RUN);
        step("tm2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, STL,  2'b00, 2'b00, S_MW);
        step("tm_trap",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, FL3,  2'b00, 2'b00, S_MW);
        step("tm_trp",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, TRP,  2'b00, 2'b00, S_TR);
        step("tm_rd1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("tm_rd2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        step("tm_run",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        step("tp",        0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FL3,  2'b00, 2'b00, S_RUN);
        step("tp_trp",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TRP,  2'b00, 2'b00, S_TR);
        step("pre_rst",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DFL,  2'b00, 2'b00, S_RD);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", act_bits(), 14'd0);
`ifdef RV_HAZARD_PERF_EN
        check("perf_rst", {stall_cnt[6:0], flush_cnt[6:0]}, 14'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 2'b00, 2'b00, S_RUN);
        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected entries never checked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
